// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants and BCD-to-segment table for the scan driver
package seg_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Segment patterns {g,f,e,d,c,b,a} for BCD 9 down to 0.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to 7-segment pattern, dash for A-F
module bcd_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = (i_nib > 4'd9) ? SEG_DASH : SEG_TABLE[i_nib];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment scanner with tear-free frame
// updates, leading-zero blanking and PWM brightness.
// Build option SEG_ACTIVE_LOW_EN: inverts seg/dp/dig_en at the output flops
// (reset value all ones) for common-anode panels; frame_done is unaffected.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int BRIGHT_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [PSC_W-1:0]    PSC_LAST  = PSC_W'(PRESCALE - 1);
    localparam logic [BRIGHT_W-1:0] SLOT_LAST = '1;
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    logic [PSC_W-1:0]          r_psc;
    logic [BRIGHT_W-1:0]       r_slot;
    logic [IDX_W-1:0]          r_idx;
    logic [4*NUM_DIGITS-1:0]   r_sh_dig;
    logic [NUM_DIGITS-1:0]     r_sh_dp;
    logic                      r_pending;
    logic [4*NUM_DIGITS-1:0]   r_disp_dig;
    logic [NUM_DIGITS-1:0]     r_disp_dp;
    logic [6:0]                r_seg;
    logic                      r_dp;
    logic [NUM_DIGITS-1:0]     r_dig_en;
    logic                      r_frame_done;

    logic                      w_tick;
    logic                      w_wrap;
    logic                      w_boundary;
    logic [3:0]                w_nib;
    logic [6:0]                w_dec;
    logic [NUM_DIGITS-1:0]     w_lz;
    logic                      w_run;
    logic                      w_blank;
    logic [6:0]                w_seg;
    logic                      w_dp;
    logic [NUM_DIGITS-1:0]     w_dig_en;

    assign w_tick     = (r_psc == PSC_LAST);
    assign w_wrap     = w_tick && (r_slot == SLOT_LAST);
    assign w_boundary = w_wrap && (r_idx == IDX_LAST);
    assign w_nib      = r_disp_dig[{r_idx, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

    // Digit k is a leading zero when it and every higher nibble are zero; digit0 never is.
    always_comb begin
        w_lz  = '0;
        w_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            w_run   = w_run && (r_disp_dig[4*k +: 4] == 4'd0);
            w_lz[k] = w_run;
        end
    end

    assign w_blank  = blank_lz && w_lz[r_idx];
    assign w_seg    = w_blank ? SEG_BLANK : w_dec;
    assign w_dp     = !w_blank && r_disp_dp[r_idx];
    assign w_dig_en = ((r_slot != '0) && (r_slot <= bright)) ? NUM_DIGITS'(1) << r_idx : '0;

    // Prescaler, slot counter and digit index; slot 0 of every digit is a forced blank tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_psc  <= '0;
            r_slot <= '0;
            r_idx  <= '0;
        end else begin
            r_psc <= w_tick ? '0 : r_psc + 1'b1;
            if (w_tick)
                r_slot <= r_slot + 1'b1;
            if (w_wrap)
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Shadow/display double buffer: display only changes at the frame boundary so a frame never tears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh_dig   <= '0;
            r_sh_dp    <= '0;
            r_pending  <= 1'b0;
            r_disp_dig <= '0;
            r_disp_dp  <= '0;
        end else begin
            if (load) begin
                r_sh_dig <= digits_in;
                r_sh_dp  <= dp_mask;
            end
            r_pending <= load ? !w_boundary : (w_boundary ? 1'b0 : r_pending);
            if (w_boundary && load) begin
                r_disp_dig <= digits_in;
                r_disp_dp  <= dp_mask;
            end else if (w_boundary && r_pending) begin
                r_disp_dig <= r_sh_dig;
                r_disp_dp  <= r_sh_dp;
            end
        end
    end

    // Output flops, polarity applied here so the panel sees clean registered levels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg        <= {7{POL}};
            r_dp         <= POL;
            r_dig_en     <= {NUM_DIGITS{POL}};
            r_frame_done <= 1'b0;
        end else begin
            r_seg        <= {7{POL}} ^ w_seg;
            r_dp         <= POL ^ w_dp;
            r_dig_en     <= {NUM_DIGITS{POL}} ^ w_dig_en;
            r_frame_done <= w_boundary;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign dig_en     = r_dig_en;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed vector table plus corner-case sequences for seg_scan_driver
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digits_in = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_mask = '0;
    logic        blank_lz = 1'b0;
    logic [2:0]  bright = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_en;
    logic        frame_done;

    int total = 0;
    int bad = 0;
    int n = -1;
    bit chk_fd = 1'b0;
    int cnt;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  m;
        logic        blz;
        logic [2:0]  br;
        int          p;
        logic [6:0]  seg;
        logic        dp;
        logic [3:0]  en;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seg_scan_driver #(.PRESCALE(1), .BRIGHT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .load       (load),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .bright     (bright),
        .seg        (seg),
        .dp         (dp),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, n);
        end
    endtask

    // One clock; outputs are examined 1 time unit after the edge. n counts edges since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        if (chk_fd)
            chk("frame_done", {31'd0, frame_done}, {31'd0, (n % 32) == 31});
    endtask

    task automatic goto(input int p);
        do tick(); while ((n % 32) != p);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] m);
        digits_in = d;
        dp_mask = m;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic add(input logic [15:0] d, input logic [3:0] m, input logic blz, input logic [2:0] br,
                       input int p, input logic [6:0] s, input logic pd, input logic [3:0] en);
        vec_t v;
        v = '{d, m, blz, br, p, s, pd, en};
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // p = position in the 32-cycle frame: digit p/8, slot p%8
        add(16'h1234, 4'h0, 0, 7,  1, 7'h66, 0, 4'b0001);
        add(16'h1234, 4'h0, 0, 7,  8, 7'h4F, 0, 4'b0000);
        add(16'h1234, 4'h0, 0, 7, 15, 7'h4F, 0, 4'b0010);
        add(16'h1234, 4'h0, 0, 7, 17, 7'h5B, 0, 4'b0100);
        add(16'h1234, 4'h0, 0, 7, 25, 7'h06, 0, 4'b1000);
        add(16'h0007, 4'h0, 1, 7,  2, 7'h07, 0, 4'b0001);
        add(16'h0007, 4'h0, 1, 7, 17, 7'h00, 0, 4'b0100);
        add(16'h0007, 4'h0, 1, 7, 26, 7'h00, 0, 4'b1000);
        add(16'h0000, 4'h0, 1, 7,  3, 7'h3F, 0, 4'b0001);
        add(16'h0000, 4'h0, 1, 7, 12, 7'h00, 0, 4'b0010);
        add(16'h0000, 4'h0, 0, 7, 12, 7'h3F, 0, 4'b0010);
        add(16'h5678, 4'h0, 0, 7,  0, 7'h7F, 0, 4'b0000);
        add(16'h5678, 4'h0, 0, 7,  9, 7'h07, 0, 4'b0010);
        add(16'h5678, 4'h0, 0, 7, 17, 7'h7D, 0, 4'b0100);
        add(16'h5678, 4'h0, 0, 7, 25, 7'h6D, 0, 4'b1000);
        add(16'h0009, 4'h0, 0, 7,  1, 7'h6F, 0, 4'b0001);
        add(16'h1234, 4'h0, 0, 3,  3, 7'h66, 0, 4'b0001);
        add(16'h1234, 4'h0, 0, 3,  4, 7'h66, 0, 4'b0000);
        add(16'h1234, 4'h0, 0, 0,  1, 7'h66, 0, 4'b0000);
        add(16'h000B, 4'h1, 0, 7,  5, 7'h40, 1, 4'b0001);
        add(16'h0005, 4'h2, 1, 7,  9, 7'h00, 0, 4'b0010);
        add(16'h0005, 4'h2, 0, 7,  9, 7'h3F, 1, 4'b0010);
        add(16'h0A00, 4'h0, 1, 7,  9, 7'h3F, 0, 4'b0010);
        add(16'h0A00, 4'h0, 1, 7, 17, 7'h40, 0, 4'b0100);
        add(16'h0A00, 4'h0, 1, 7, 25, 7'h00, 0, 4'b1000);
        add(16'hF000, 4'h8, 0, 7, 27, 7'h40, 1, 4'b1000);

        repeat (3) @(posedge clk);
        #1;
        chk("reset seg", {25'd0, seg}, 32'd0);
        chk("reset dp", {31'd0, dp}, 32'd0);
        chk("reset dig_en", {28'd0, dig_en}, 32'd0);
        chk("reset frame_done", {31'd0, frame_done}, 32'd0);
        #1 reset = 1'b1;
        n = -1;
        chk_fd = 1'b1;

        foreach (vecs[i]) begin
            blank_lz = vecs[i].blz;
            bright = vecs[i].br;
            do_load(vecs[i].d, vecs[i].m);
            while ((n % 32) != 31) tick();
            goto(vecs[i].p);
            chk($sformatf("vec%0d seg", i), {25'd0, seg}, {25'd0, vecs[i].seg});
            chk($sformatf("vec%0d dp", i), {31'd0, dp}, {31'd0, vecs[i].dp});
            chk($sformatf("vec%0d dig_en", i), {28'd0, dig_en}, {28'd0, vecs[i].en});
        end

        // PWM duty: on-cycles per slot and per frame
        blank_lz = 1'b0;
        bright = 3'd3;
        goto(31);
        cnt = 0;
        repeat (8) begin tick(); cnt += (dig_en != 0); end
        chk("duty bright3", cnt, 3);
        bright = 3'd0;
        cnt = 0;
        repeat (64) begin tick(); cnt += (dig_en != 0); end
        chk("duty bright0", cnt, 0);
        bright = 3'd7;
        goto(31);
        cnt = 0;
        repeat (32) begin tick(); cnt += (dig_en != 0); end
        chk("duty bright7", cnt, 28);

        // Mid-frame load stays invisible until the next frame
        do_load(16'h1234, 4'h0);
        while ((n % 32) != 31) tick();
        goto(10);
        do_load(16'h5678, 4'h0);
        goto(17);
        chk("midload old d2", {25'd0, seg}, 32'h5B);
        goto(25);
        chk("midload old d3", {25'd0, seg}, 32'h06);
        goto(1);
        chk("midload new d0", {25'd0, seg}, 32'h7F);
        goto(9);
        chk("midload new d1", {25'd0, seg}, 32'h07);

        // Two loads in one frame: the later one is displayed
        goto(2);
        do_load(16'h9999, 4'h0);
        goto(5);
        do_load(16'h4321, 4'h0);
        goto(1);
        chk("lastwins d0", {25'd0, seg}, 32'h06);
        goto(25);
        chk("lastwins d3", {25'd0, seg}, 32'h66);

        // Load on the boundary cycle commits into the frame that starts right after
        goto(30);
        do_load(16'h1234, 4'h0);
        tick();
        chk("bndload d0", {25'd0, seg}, 32'h66);
        goto(25);
        chk("bndload d3", {25'd0, seg}, 32'h06);

        // Asynchronous reset in the middle of a lit slot
        goto(12);
        chk("pre-reset dig_en", {28'd0, dig_en}, 32'h2);
        #3 reset = 1'b0;
        #1;
        chk("async seg", {25'd0, seg}, 32'd0);
        chk("async dp", {31'd0, dp}, 32'd0);
        chk("async dig_en", {28'd0, dig_en}, 32'd0);
        chk("async frame_done", {31'd0, frame_done}, 32'd0);
        chk_fd = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        n = -1;
        chk_fd = 1'b1;
        tick();
        chk("restart seg", {25'd0, seg}, 32'h3F);
        chk("restart slot0", {28'd0, dig_en}, 32'd0);
        tick();
        chk("restart d0 on", {28'd0, dig_en}, 32'h1);
        goto(9);
        chk("restart d1 on", {28'd0, dig_en}, 32'h2);
        goto(31);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
